// File: rtl/argmax_stream_ctrl.sv
// argmax_stream_ctrl
//   Streaming argmax over frames of unsigned M-bit elements delivered as
//   chunks of 2**S elements. Each chunk is reduced combinationally to a local
//   max/index. A running best is kept across up to 2**K chunks, and one
//   registered result per frame is presented on a valid/ready handshake.
//
// Ports
//   clk, rst_n      clock, async active-low reset
//   flush           synchronous abort of the partial frame (ignored in DONE)
//   in_valid/ready  chunk handshake; in_ready depends only on the state
//   in_data         chunk, element e at [M*(e+1)-1 : M*e]
//   in_last         chunk ends the frame
//   out_valid/ready result handshake
//   out_max/ind     frame maximum and its global element index
//   out_trunc       frame ended by the capacity limit rather than in_last

// One comparator node of the reduction tree. The right operand (higher
// element index) wins ties.
module argmax_node #(
  parameter int M  = 8,
  parameter int IW = 2
) (
  input  logic [M-1:0]  a_v,
  input  logic [IW-1:0] a_i,
  input  logic [M-1:0]  b_v,
  input  logic [IW-1:0] b_i,
  output logic [M-1:0]  o_v,
  output logic [IW-1:0] o_i
);
  logic sel_b;
  assign sel_b = (b_v >= a_v);
  assign o_v   = sel_b ? b_v : a_v;
  assign o_i   = sel_b ? b_i : a_i;
endmodule

module argmax_stream_ctrl #(
  parameter int S = 2,
  parameter int M = 8,
  parameter int K = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [M*(2**S)-1:0] in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [M-1:0]        out_max,
  output logic [S+K-1:0]      out_ind,
  output logic                out_trunc
);
  localparam int N = 2**S;

  typedef enum logic {ACC, DONE} st_t;

  st_t            st;
  logic [K-1:0]   cnt;
  logic [M-1:0]   best;
  logic [S+K-1:0] idx;

  // Reduction tree: level l holds N>>l candidates; level S is the chunk result.
  for (genvar l = 0; l <= S; l++) begin : lv
    localparam int NN = N >> l;
    logic [NN-1:0][M-1:0] v;
    logic [NN-1:0][S-1:0] ix;
    if (l == 0) begin : g_leaf
      for (genvar e = 0; e < N; e++) begin : g_el
        assign v[e]  = in_data[M*e +: M];
        assign ix[e] = S'(e);
      end
    end else begin : g_node
      for (genvar j = 0; j < NN; j++) begin : g_n
        argmax_node #(.M(M), .IW(S)) u_node (
          .a_v (lv[l-1].v[2*j]),
          .a_i (lv[l-1].ix[2*j]),
          .b_v (lv[l-1].v[2*j+1]),
          .b_i (lv[l-1].ix[2*j+1]),
          .o_v (v[j]),
          .o_i (ix[j])
        );
      end
    end
  end

  logic [M-1:0]   lmax;
  logic [S-1:0]   li;
  logic [S+K-1:0] gi;
  logic           take;
  logic [M-1:0]   nbest;
  logic [S+K-1:0] nidx;
  logic           hs;
  logic           fend;

  assign lmax  = lv[S].v[0];
  assign li    = lv[S].ix[0];
  assign gi    = {cnt, li};
  // First chunk of a frame loads unconditionally; later chunks win ties.
  assign take  = (cnt == '0) || (lmax >= best);
  assign nbest = take ? lmax : best;
  assign nidx  = take ? gi : idx;

  // Gated by rst_n so nothing is offered while reset is held.
  assign in_ready = (st == ACC) && rst_n;
  assign hs       = in_valid && in_ready;
  assign fend     = in_last || (cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ACC;
      cnt       <= '0;
      best      <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_max   <= '0;
      out_ind   <= '0;
      out_trunc <= 1'b0;
    end else begin
      case (st)
        ACC: begin
          if (flush) begin
            cnt  <= '0;
            best <= '0;
            idx  <= '0;
          end else if (hs) begin
            best <= nbest;
            idx  <= nidx;
            if (fend) begin
              out_max   <= nbest;
              out_ind   <= nidx;
              out_trunc <= ~in_last;
              out_valid <= 1'b1;
              cnt       <= '0;
              st        <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            st        <= ACC;
          end
        end
        default: st <= ACC;
      endcase
    end
  end
endmodule

// File: tb/tb_argmax_stream_ctrl.sv
// Scoreboard bench for argmax_stream_ctrl (S=2, M=8, K=2). A frame-level
// reference model collects accepted elements and, at frame end, scans them
// for the maximum (highest index wins ties), pushing the expected result. A
// monitor pops on each new out_valid and checks the held result every cycle.
module tb_argmax_stream_ctrl;
  localparam int S = 2;
  localparam int M = 8;
  localparam int K = 2;
  localparam int N = 2**S;
  localparam int W = M*N;
  localparam int MAXCH = 2**K;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic           in_last = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [M-1:0]   out_max;
  logic [S+K-1:0] out_ind;
  logic           out_trunc;

  argmax_stream_ctrl #(.S(S), .M(M), .K(K)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_ind(out_ind), .out_trunc(out_trunc)
  );

  always #5 clk = ~clk;

  typedef struct {int mx; int ind; int tr;} exp_t;
  exp_t q[$];
  int   frame[$];
  int   nch = 0;
  bit   mdone = 0;   // model: result outstanding
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pk(input int e0, input int e1, input int e2, input int e3);
    pk = {e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
  endfunction

  // Reference model, updated on the accepting edge.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        frame.delete(); nch = 0; mdone = 0; q.delete();
      end else if (!mdone) begin
        if (flush) begin
          frame.delete(); nch = 0;
        end else if (in_valid) begin
          for (int e = 0; e < N; e++) frame.push_back(int'(in_data[M*e +: M]));
          nch++;
          if (in_last || nch == MAXCH) begin
            exp_t x;
            x.mx = -1; x.ind = 0; x.tr = in_last ? 0 : 1;
            foreach (frame[i]) if (frame[i] >= x.mx) begin x.mx = frame[i]; x.ind = i; end
            q.push_back(x);
            frame.delete(); nch = 0; mdone = 1;
          end
        end
      end else if (out_ready) begin
        mdone = 0;
      end
    end
  end

  // Monitor, samples on the falling edge.
  exp_t cur;
  bit   seen = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outs", int'({in_ready, out_valid, out_max, out_ind, out_trunc}), 0);
        seen = 0;
      end else begin
        chk("in_ready", int'(in_ready), mdone ? 0 : 1);
        chk("out_valid", int'(out_valid), mdone ? 1 : 0);
        if (out_valid) begin
          if (!seen) begin
            if (q.size() == 0) begin
              chk("unexpected_result", 1, 0);
              cur.mx = -1; cur.ind = -1; cur.tr = -1;
            end else cur = q.pop_front();
            seen = 1;
          end
          chk("out_max", int'(out_max), cur.mx);
          chk("out_ind", int'(out_ind), cur.ind);
          chk("out_trunc", int'(out_trunc), cur.tr);
        end else seen = 0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input bit last, input bit fl);
    bit ok = 0;
    in_valid = 1'b1; in_data = d; in_last = last; flush = fl;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; flush = 1'b0;
  endtask

  task automatic expect_out(input string name, input int mx, input int ind, input int tr);
    bit ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    chk({name, "_valid"}, int'(ok), 1);
    if (ok) begin
      chk({name, "_max"}, int'(out_max), mx);
      chk({name, "_ind"}, int'(out_ind), ind);
      chk({name, "_trunc"}, int'(out_trunc), tr);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [M-1:0] h_max;
    logic [S+K-1:0] h_ind;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // single chunk
    send(pk(3, 9, 9, 1), 1, 0);
    expect_out("single", 9, 2, 0);
    // multi-chunk with cross-chunk tie, back to back then with gaps
    send(pk(0, 50, 0, 0), 0, 0); send(pk(0, 0, 0, 200), 0, 0); send(pk(200, 0, 0, 0), 1, 0);
    expect_out("tie", 200, 8, 0);
    send(pk(0, 50, 0, 0), 0, 0); idle(2); send(pk(0, 0, 0, 200), 0, 0); idle(1);
    send(pk(200, 0, 0, 0), 1, 0);
    expect_out("tie_gap", 200, 8, 0);
    // capacity truncation, then a fresh frame
    send(pk(0, 0, 0, 0), 0, 0); send(pk(0, 0, 0, 0), 0, 0); send(pk(0, 0, 0, 0), 0, 0);
    send(pk(0, 0, 7, 0), 0, 0);
    expect_out("trunc", 7, 14, 1);
    send(pk(5, 0, 0, 0), 1, 0);
    expect_out("after_trunc", 5, 0, 0);

    // backpressure
    out_ready = 1'b0;
    send(pk(1, 8, 2, 3), 1, 0);
    @(negedge clk); h_max = out_max; h_ind = out_ind;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold", int'({out_valid, in_ready, out_max, out_ind}), int'({1'b1, 1'b0, h_max, h_ind}));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_release", int'({out_valid, in_ready}), 1);
    out_ready = 1'b1;

    // flush discards partial frame; flush beats a handshaked chunk
    send(pk(99, 0, 0, 0), 0, 0); send(pk(0, 0, 0, 0), 0, 0);
    flush = 1'b1; idle(1); flush = 1'b0; idle(2);
    send(pk(1, 2, 3, 4), 1, 0);
    expect_out("flush", 4, 3, 0);
    send(pk(200, 0, 0, 0), 1, 1);
    idle(2);
    send(pk(0, 9, 0, 0), 1, 0);
    expect_out("flush_hs", 9, 1, 0);

    // all-zero frame
    send(pk(0, 0, 0, 0), 0, 0); send(pk(0, 0, 0, 0), 0, 0); send(pk(0, 0, 0, 0), 0, 0);
    send(pk(0, 0, 0, 0), 1, 0);
    expect_out("zeros", 0, 15, 0);

    // async reset mid-frame and while holding a result
    send(pk(4, 4, 0, 0), 0, 0);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_frame", int'({in_ready, out_valid, out_max, out_ind, out_trunc}), 0);
    idle(2); rst_n = 1'b1; idle(1);
    out_ready = 1'b0;
    send(pk(0, 0, 0, 77), 1, 0);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_done", int'({in_ready, out_valid, out_max, out_ind, out_trunc}), 0);
    idle(2); rst_n = 1'b1; out_ready = 1'b1; idle(1);
    send(pk(0, 0, 6, 0), 1, 0);
    expect_out("post_reset", 6, 2, 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      for (int e = 0; e < N; e++)
        in_data[M*e +: M] = ($urandom_range(0, 1) != 0) ? M'($urandom_range(0, 3)) : M'($urandom);
      in_last   = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 1) != 0);
      idle(1);
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    idle(6);
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
